fir_out_sink: RTL and testbench



---
 rtl/fir_out_sink.sv | 126 ++++++++++++
 tb/tb_fir_out_sink.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_out_sink.sv
// Output-side consumer for the parallel FIR filter. It scales 29-bit results to 12-bit samples and buffers them in a show-ahead FIFO.
// Optional round-half-up scaling is enabled by defining FIR_OUT_ROUND_EN. Without it, the result is plain truncation.
module fir_out_sink #(
  parameter int IW    = 29,
  parameter int OW    = 12,
  parameter int SHIFT = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [IW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_data,
  output logic [7:0]               sat_cnt,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef FIR_OUT_ROUND_EN
  localparam logic [IW:0] RND = (IW+1)'(1) << (SHIFT - 1);
`else
  localparam logic [IW:0] RND = '0;
`endif

  logic [IW:0]    sum;
  logic [IW:0]    scaled;
  logic           sat;

  logic           s1_v_q;
  logic [OW-1:0]  s1_data_q;
  logic [7:0]     sat_cnt_q;

  logic [OW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           drop;

  // The extra sum bit keeps the rounding constant from wrapping large inputs.
  assign sum    = {1'b0, in_data} + RND;
  assign scaled = sum >> SHIFT;
  assign sat    = |scaled[IW:OW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= sat ? '1 : scaled[OW-1:0];
        if (sat && sat_cnt_q != 8'hFF) begin
          sat_cnt_q <= sat_cnt_q + 8'd1;
        end
      end
    end
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept data.
  assign push  = s1_v_q && (!full || pop);
  assign drop  = s1_v_q && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  // The array is never reset, so the output is gated by the empty flag.
  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign sat_cnt    = sat_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_fir_out_sink.sv
// Directed self-checking bench for fir_out_sink. Expected values are hand-computed.
// The expected values follow the FIR_OUT_ROUND_EN setting of the build.
module tb_fir_out_sink;

`ifdef FIR_OUT_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        inValid;
   logic [28:0] inData;
   logic        outValid;
   logic        outReady;
   logic [11:0] outData;
   logic [7:0]  satCnt;
   logic [7:0]  dropCnt;
   logic [2:0]  fifoLevel;

   int nAsserts = 0;
   int nFails   = 0;

   fir_out_sink dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (inValid),
      .in_data    (inData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_data   (outData),
      .sat_cnt    (satCnt),
      .drop_cnt   (dropCnt),
      .fifo_level (fifoLevel)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one input beat to the scaling stage
   task automatic applyStimulus(input logic valid, input logic [28:0] data);
      inValid = valid;
      inData  = data;
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Synchronously time an asynchronous reset pulse and leave inputs idle
   task automatic resetDut();
      applyStimulus(1'b0, '0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Single strobe into an empty FIFO; sample must appear two edges later and then pop
   task automatic singleSample(input string tag, input logic [28:0] data, input logic [11:0] exp);
      applyStimulus(1'b1, data);
      tick();
      applyStimulus(1'b0, '0);
      checkOutput({tag, "_notyet"}, outValid, 0);
      tick();
      checkOutput({tag, "_valid"}, outValid, 1);
      checkOutput({tag, "_data"}, outData, exp);
      tick();
      checkOutput({tag, "_popped"}, outValid, 0);
   endtask

   initial begin
      rst      = 1'b1;
      outReady = 1'b0;
      applyStimulus(1'b0, '0);
      $display("[TB] Start, rounding build = %0d", ROUND);

      resetDut();
      checkOutput("rst_valid", outValid, 0);
      checkOutput("rst_data", outData, 0);
      checkOutput("rst_sat", satCnt, 0);
      checkOutput("rst_drop", dropCnt, 0);
      checkOutput("rst_level", fifoLevel, 0);

      outReady = 1'b1;
      singleSample("unity", 29'd204800, 12'd100);
      singleSample("round_half", 29'd11264, ROUND ? 12'd6 : 12'd5);
      singleSample("round_below", 29'd11263, 12'd5);

      singleSample("sat_big", 29'd8388608, 12'd4095);
      checkOutput("sat_cnt1", satCnt, 1);
      singleSample("sat_edge", 29'd8387584, 12'd4095);
      checkOutput("sat_cnt2", satCnt, ROUND ? 2 : 1);

      outReady = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b1, 29'(k * 2048));
         tick();
      end
      applyStimulus(1'b0, '0);
      tick();
      checkOutput("full_level", fifoLevel, 4);
      checkOutput("full_drop", dropCnt, 2);
      outReady = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checkOutput("drain_valid", outValid, 1);
         checkOutput("drain_data", outData, k);
         tick();
      end
      checkOutput("drain_empty", outValid, 0);
      checkOutput("drain_level", fifoLevel, 0);

      resetDut();
      outReady = 1'b0;
      for (int k = 10; k <= 14; k++) begin
         applyStimulus(1'b1, 29'(k * 2048));
         tick();
      end
      checkOutput("fp_fill_level", fifoLevel, 4);
      outReady = 1'b1;
      for (int j = 0; j < 6; j++) begin
         applyStimulus(1'b1, 29'((15 + j) * 2048));
         checkOutput("fp_level", fifoLevel, 4);
         checkOutput("fp_data", outData, 10 + j);
         tick();
      end
      applyStimulus(1'b0, '0);
      checkOutput("fp_drop", dropCnt, 0);
      for (int k = 16; k <= 20; k++) begin
         checkOutput("fp_tail", outData, k);
         tick();
      end
      checkOutput("fp_empty", outValid, 0);

      resetDut();
      outReady = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 29'(k * 2048));
         tick();
      end
      checkOutput("mid_level", fifoLevel, 3);
      rst = 1'b1;
      applyStimulus(1'b0, '0);
      #1;
      checkOutput("mid_async_level", fifoLevel, 0);
      tick();
      checkOutput("mid_valid", outValid, 0);
      checkOutput("mid_level0", fifoLevel, 0);
      checkOutput("mid_sat", satCnt, 0);
      checkOutput("mid_drop", dropCnt, 0);
      rst = 1'b0;
      tick();
      outReady = 1'b1;
      singleSample("post_rst", 29'(7 * 2048), 12'd7);

      outReady = 1'b0;
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'b1, 29'd8388608);
         tick();
      end
      applyStimulus(1'b0, '0);
      tick();
      checkOutput("stick_sat", satCnt, 255);
      checkOutput("stick_drop", dropCnt, 255);
      checkOutput("stick_level", fifoLevel, 4);
      checkOutput("stick_data", outData, 4095);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
